bp_update_ctrl: RTL and testbench

- Controller for the GShare/BTB predictor.
- After reset it sequences an init sweep that clears every predictor entry, one index per cycle.
- It detects mispredictions at EX and drives the pipeline flush/redirect.
- It buffers resolved-branch updates from EX in a small FIFO and issues them to the predictor's update port one per accepted handshake.

---
 rtl/bp_update_ctrl_if.sv | 48 ++++
 rtl/bp_update_ctrl.sv | 139 +++++++++++++
 tb/tb_bp_update_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/bp_update_ctrl_if.sv
// Bundles for the branch predictor update controller.
// bp_ex_if: EX-stage resolution bus (master = EX stage, slave = controller).
// bp_upd_if: predictor update port (master = controller, slave = predictor).

`ifndef BCOND_TAKEN
`define BCOND_TAKEN     2'b11
`endif
`ifndef BCOND_NOT_TAKEN
`define BCOND_NOT_TAKEN 2'b10
`endif

interface bp_ex_if;
    logic        ex_valid;
    logic [1:0]  ex_bcond;
    logic        ex_is_jump;
    logic [31:0] ex_pc;
    logic [31:0] ex_pred_next_pc;
    logic [31:0] ex_correct_next_pc;
    logic        ex_stall;
    logic        flush;
    logic [31:0] redirect_pc;

    modport master (
        output ex_valid, ex_bcond, ex_is_jump, ex_pc, ex_pred_next_pc, ex_correct_next_pc,
        input  ex_stall, flush, redirect_pc
    );
    modport slave (
        input  ex_valid, ex_bcond, ex_is_jump, ex_pc, ex_pred_next_pc, ex_correct_next_pc,
        output ex_stall, flush, redirect_pc
    );
endinterface

interface bp_upd_if;
    logic        upd_valid;
    logic        upd_ready;
    logic        upd_taken;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;

    modport master (
        output upd_valid, upd_taken, upd_pc, upd_target,
        input  upd_ready
    );
    modport slave (
        input  upd_valid, upd_taken, upd_pc, upd_target,
        output upd_ready
    );
endinterface

// File: rtl/bp_update_ctrl.sv
// GShare/BTB controller: init sweep after reset, EX mispredict flush/redirect, update FIFO to predictor.
// Latency: flush/redirect combinational from EX; push-to-upd_valid at least 1 cycle (no bypass).
// Backpressure: upd_ready stalls FIFO head; full FIFO raises ex_stall so EX re-presents its branch.
// Ports: clk, reset (async, active low); ex (bp_ex_if.slave) EX resolution in, flush/redirect/stall out;
//        upd (bp_upd_if.master) update port; init_valid/init_index sweep; pred_enable; mispredict_count.

`ifndef BCOND_TAKEN
`define BCOND_TAKEN     2'b11
`endif
`ifndef BCOND_NOT_TAKEN
`define BCOND_NOT_TAKEN 2'b10
`endif

module bp_update_ctrl #(
    parameter int DEPTH   = 4,
    parameter int ENTRIES = 32,
    parameter int IDX_W   = 5
) (
    input  logic             clk,
    input  logic             reset,
    bp_ex_if.slave           ex,
    bp_upd_if.master         upd,
    output logic             init_valid,
    output logic [IDX_W-1:0] init_index,
    output logic             pred_enable,
    output logic [31:0]      mispredict_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    typedef struct packed {
        logic        taken;
        logic [31:0] pc;
        logic [31:0] target;
    } upd_entry_t;

    logic [0:0]  state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    upd_entry_t  fifo_mem [DEPTH];
    upd_entry_t  head;

    logic is_cond;
    logic resolved;
    logic taken;
    logic mispredict;
    logic full;
    logic empty;
    logic push;
    logic pop;

    // Branch resolution and misprediction detection, independent of FSM state.
    always_comb begin
        is_cond    = (ex.ex_bcond == `BCOND_TAKEN) || (ex.ex_bcond == `BCOND_NOT_TAKEN);
        resolved   = ex.ex_valid && (is_cond || ex.ex_is_jump);
        taken      = ex.ex_is_jump || (ex.ex_bcond == `BCOND_TAKEN);
        mispredict = resolved && (ex.ex_pred_next_pc != ex.ex_correct_next_pc);
    end

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // The stall depends on full alone, so a pop in the same cycle does not let
    // the stalled branch in; it lands on the following cycle instead.
    assign push  = resolved && !full;
    assign pop   = upd.upd_valid && upd.upd_ready;

    assign ex.flush       = mispredict;
    assign ex.redirect_pc = ex.ex_correct_next_pc;
    assign ex.ex_stall    = resolved && full;

    assign head           = fifo_mem[rd_ptr];
    assign upd.upd_valid  = (state == S_RUN) && !empty;
    assign upd.upd_taken  = head.taken;
    assign upd.upd_pc     = head.pc;
    assign upd.upd_target = head.target;

    // Gated by reset so the clear strobe is quiet while reset is held,
    // even though the state register already sits in INIT.
    assign init_valid  = (state == S_INIT) && reset;
    assign pred_enable = (state == S_RUN);

    // Init sweep FSM: ENTRIES cycles of clears, then RUN until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_INIT;
            init_index <= '0;
        end else if (state == S_INIT) begin
            if (init_index == IDX_W'(ENTRIES - 1)) begin
                state <= S_RUN;
            end else begin
                init_index <= init_index + IDX_W'(1);
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{taken: taken, pc: ex.ex_pc, target: ex.ex_correct_next_pc};
        end
    end

    // A stalled mispredict is counted once, when EX finally gets through.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mispredict_count <= '0;
        end else if (ex.flush && !ex.ex_stall && (mispredict_count != 32'hFFFF_FFFF)) begin
            mispredict_count <= mispredict_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Directed bench for bp_update_ctrl: init sweep, vector table in RUN,
// full-FIFO stall with wrap, INIT-time pushes and mid-operation reset.

`ifndef BCOND_TAKEN
`define BCOND_TAKEN     2'b11
`endif
`ifndef BCOND_NOT_TAKEN
`define BCOND_NOT_TAKEN 2'b10
`endif

module tb_bp_update_ctrl;

    logic        clk;
    logic        reset;
    logic        init_valid;
    logic [4:0]  init_index;
    logic        pred_enable;
    logic [31:0] mispredict_count;

    bp_ex_if  ex_bus ();
    bp_upd_if upd_bus ();

    bp_update_ctrl #(.DEPTH(4), .ENTRIES(32), .IDX_W(5)) dut (
        .clk              (clk),
        .reset            (reset),
        .ex               (ex_bus),
        .upd              (upd_bus),
        .init_valid       (init_valid),
        .init_index       (init_index),
        .pred_enable      (pred_enable),
        .mispredict_count (mispredict_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        valid;
        logic [1:0]  bcond;
        logic        jump;
        logic [31:0] pc;
        logic [31:0] pred;
        logic [31:0] corr;
        logic        rdy;
        logic        e_flush;
        logic [31:0] e_redirect;
        logic        e_stall;
        logic        e_uvalid;
        logic        e_utaken;
        logic [31:0] e_upc;
        logic [31:0] e_utarget;
        logic [31:0] e_mcount;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [1:0] bc, input logic j,
                          input logic [31:0] pc, input logic [31:0] pred, input logic [31:0] corr);
        ex_bus.ex_valid           = v;
        ex_bus.ex_bcond           = bc;
        ex_bus.ex_is_jump         = j;
        ex_bus.ex_pc              = pc;
        ex_bus.ex_pred_next_pc    = pred;
        ex_bus.ex_correct_next_pc = corr;
    endtask

    task automatic chk_head(input string tag, input logic tk, input logic [31:0] pc, input logic [31:0] tgt);
        chk({tag, "_upd_valid"},  32'(upd_bus.upd_valid), 32'd1);
        chk({tag, "_upd_taken"},  32'(upd_bus.upd_taken), 32'(tk));
        chk({tag, "_upd_pc"},     upd_bus.upd_pc, pc);
        chk({tag, "_upd_target"}, upd_bus.upd_target, tgt);
    endtask

    initial begin
        //          valid bcond               jmp  pc        pred      corr      rdy  flush redir     stall uv  ut  upc       utgt      mcount
        vecs[0] = '{1'b1, `BCOND_TAKEN,     1'b0, 32'h40,  32'h44,  32'h80,  1'b1, 1'b1, 32'h80,  1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'd0};
        vecs[1] = '{1'b0, 2'b00,            1'b0, 32'h0,   32'h0,   32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h40,  32'h80,  32'd1};
        vecs[2] = '{1'b1, `BCOND_NOT_TAKEN, 1'b0, 32'h100, 32'h104, 32'h104, 1'b1, 1'b0, 32'h104, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'd1};
        vecs[3] = '{1'b0, 2'b00,            1'b0, 32'h0,   32'h0,   32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h100, 32'h104, 32'd1};
        vecs[4] = '{1'b1, 2'b00,            1'b1, 32'h200, 32'h204, 32'h300, 1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'd1};
        vecs[5] = '{1'b1, 2'b00,            1'b0, 32'h210, 32'h214, 32'h999, 1'b0, 1'b0, 32'h999, 1'b0, 1'b1, 1'b1, 32'h200, 32'h300, 32'd2};
        vecs[6] = '{1'b0, `BCOND_TAKEN,     1'b0, 32'h220, 32'h0,   32'h50,  1'b1, 1'b0, 32'h50,  1'b0, 1'b1, 1'b1, 32'h200, 32'h300, 32'd2};
        vecs[7] = '{1'b0, 2'b00,            1'b0, 32'h0,   32'h0,   32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'd2};

        // ---- reset and first init sweep ----
        reset = 1'b0;
        upd_bus.upd_ready = 1'b0;
        set_ex(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
        repeat (3) tick();
        chk("rst_upd_valid",   32'(upd_bus.upd_valid), 32'd0);
        chk("rst_init_valid",  32'(init_valid), 32'd0);
        chk("rst_pred_enable", 32'(pred_enable), 32'd0);
        chk("rst_ex_stall",    32'(ex_bus.ex_stall), 32'd0);
        chk("rst_mcount",      mispredict_count, 32'd0);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("sweep%0d_init_valid", i), 32'(init_valid), 32'd1);
            chk($sformatf("sweep%0d_init_index", i), 32'(init_index), 32'(i));
            chk($sformatf("sweep%0d_upd_valid", i),  32'(upd_bus.upd_valid), 32'd0);
            chk($sformatf("sweep%0d_pred_en", i),    32'(pred_enable), 32'd0);
            tick();
        end
        chk("run_init_valid",  32'(init_valid), 32'd0);
        chk("run_pred_enable", 32'(pred_enable), 32'd1);
        chk("run_init_index",  32'(init_index), 32'd31);
        tick();
        chk("run_init_valid_hold", 32'(init_valid), 32'd0);

        // ---- table-driven RUN vectors ----
        for (int i = 0; i < 8; i++) begin
            set_ex(vecs[i].valid, vecs[i].bcond, vecs[i].jump, vecs[i].pc, vecs[i].pred, vecs[i].corr);
            upd_bus.upd_ready = vecs[i].rdy;
            #1;
            chk($sformatf("v%0d_flush", i),     32'(ex_bus.flush), 32'(vecs[i].e_flush));
            if (vecs[i].e_flush)
                chk($sformatf("v%0d_redirect", i), ex_bus.redirect_pc, vecs[i].e_redirect);
            chk($sformatf("v%0d_stall", i),     32'(ex_bus.ex_stall), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d_upd_valid", i), 32'(upd_bus.upd_valid), 32'(vecs[i].e_uvalid));
            if (vecs[i].e_uvalid) begin
                chk($sformatf("v%0d_upd_taken", i),  32'(upd_bus.upd_taken), 32'(vecs[i].e_utaken));
                chk($sformatf("v%0d_upd_pc", i),     upd_bus.upd_pc, vecs[i].e_upc);
                chk($sformatf("v%0d_upd_target", i), upd_bus.upd_target, vecs[i].e_utarget);
            end
            chk($sformatf("v%0d_mcount", i), mispredict_count, vecs[i].e_mcount);
            tick();
        end

        // ---- full FIFO stall, pointer wrap, drain order ----
        upd_bus.upd_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            set_ex(1'b1, (i % 2) ? `BCOND_TAKEN : `BCOND_NOT_TAKEN, 1'b0, 32'(i), 32'(32'h100 + i), 32'(32'h100 + i));
            #1;
            chk($sformatf("fill%0d_stall", i), 32'(ex_bus.ex_stall), 32'd0);
            tick();
        end
        set_ex(1'b1, `BCOND_TAKEN, 1'b0, 32'd5, 32'h0, 32'h105);
        #1;
        chk("full_stall",     32'(ex_bus.ex_stall), 32'd1);
        chk("full_flush",     32'(ex_bus.flush), 32'd1);
        chk("full_redirect",  ex_bus.redirect_pc, 32'h105);
        tick();
        chk("stalled_mcount", mispredict_count, 32'd2);
        chk("stalled_stall",  32'(ex_bus.ex_stall), 32'd1);
        chk_head("stalled_head", 1'b1, 32'd1, 32'h101);
        upd_bus.upd_ready = 1'b1;
        #1;
        chk("pop_full_stall", 32'(ex_bus.ex_stall), 32'd1);
        tick();
        chk("after_pop_stall", 32'(ex_bus.ex_stall), 32'd0);
        chk("after_pop_flush", 32'(ex_bus.flush), 32'd1);
        chk("after_pop_mcount", mispredict_count, 32'd2);
        chk_head("drain2", 1'b0, 32'd2, 32'h102);
        tick();
        set_ex(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
        #1;
        chk("push5_mcount", mispredict_count, 32'd3);
        chk_head("drain3", 1'b1, 32'd3, 32'h103);
        tick();
        chk_head("drain4", 1'b0, 32'd4, 32'h104);
        tick();
        chk_head("drain5", 1'b1, 32'd5, 32'h105);
        tick();
        chk("drained_upd_valid", 32'(upd_bus.upd_valid), 32'd0);
        chk("drained_mcount", mispredict_count, 32'd3);

        // ---- reset with pending entries, then pushes during INIT ----
        upd_bus.upd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_ex(1'b1, `BCOND_TAKEN, 1'b0, 32'(32'hA0 + 4 * i), 32'hB0, 32'hB0);
            tick();
        end
        set_ex(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
        #1;
        chk("pending_upd_valid", 32'(upd_bus.upd_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_upd_valid",  32'(upd_bus.upd_valid), 32'd0);
        chk("midrst_init_valid", 32'(init_valid), 32'd0);
        chk("midrst_pred_en",    32'(pred_enable), 32'd0);
        chk("midrst_mcount",     mispredict_count, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        upd_bus.upd_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i == 0)
                set_ex(1'b1, `BCOND_TAKEN, 1'b0, 32'hC0, 32'hD0, 32'hD0);
            else if (i == 1)
                set_ex(1'b1, `BCOND_NOT_TAKEN, 1'b0, 32'hC4, 32'hD4, 32'hD4);
            else
                set_ex(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
            #1;
            chk($sformatf("resweep%0d_init_valid", i), 32'(init_valid), 32'd1);
            chk($sformatf("resweep%0d_init_index", i), 32'(init_index), 32'(i));
            chk($sformatf("resweep%0d_upd_valid", i),  32'(upd_bus.upd_valid), 32'd0);
            chk($sformatf("resweep%0d_flush", i),      32'(ex_bus.flush), 32'd0);
            tick();
        end
        chk("rerun_pred_enable", 32'(pred_enable), 32'd1);
        chk_head("init_push0", 1'b1, 32'hC0, 32'hD0);
        tick();
        chk_head("init_push1", 1'b0, 32'hC4, 32'hD4);
        tick();
        chk("no_stale_upd_valid", 32'(upd_bus.upd_valid), 32'd0);
        tick();
        chk("no_stale_upd_valid2", 32'(upd_bus.upd_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
